instr_loader: RTL and testbench

Byte-stream program loader that fills the instruction memory before the core runs. It receives a length-prefixed, little-endian byte stream over a valid/ready handshake and assembles 32-bit words. Each word is written through a single-cycle write port at consecutive word addresses. `busy_o` holds the core in reset until loading completes; `done_o` and `error_o` report the outcome.

---
 rtl/instr_loader.sv | 117 +++++++++++
 tb/tb_instr_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Byte-stream program loader: takes a little-endian word count followed by that many
// little-endian 32-bit words and writes them to consecutive instruction-memory addresses.
module instr_loader #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        start_i,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [1:0] {HDR, DATA, DONE, ERR} state_t;

  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

  state_t      state;
  logic [1:0]  bcnt;
  logic [23:0] shreg;
  logic [31:0] n;
  logic [31:0] wcnt;
  logic [31:0] addr;

  logic        acc;
  logic [31:0] word_full;
  logic [31:0] wcnt_nxt;

  assign acc       = valid_i && ready_o;
  // Earlier bytes sit in shreg with the oldest at the bottom, so the 4th byte completes the word.
  assign word_full = {data_i, shreg};
  assign wcnt_nxt  = wcnt + 32'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= HDR;
      bcnt    <= '0;
      shreg   <= '0;
      n       <= '0;
      wcnt    <= '0;
      addr    <= BASE_ADDR;
      we_o    <= 1'b0;
      waddr_o <= BASE_ADDR;
      wdata_o <= '0;
      ready_o <= 1'b1;
      busy_o  <= 1'b1;
      done_o  <= 1'b0;
      error_o <= 1'b0;
    end else begin
      we_o <= 1'b0;
      case (state)
        HDR: begin
          if (acc) begin
            bcnt  <= bcnt + 2'd1;
            shreg <= {data_i, shreg[23:8]};
            if (bcnt == 2'd3) begin
              n <= word_full;
              if (word_full == '0) begin
                state   <= DONE;
                ready_o <= 1'b0;
                busy_o  <= 1'b0;
                done_o  <= 1'b1;
              end else if (word_full > DEPTH32) begin
                state   <= ERR;
                ready_o <= 1'b0;
                error_o <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (acc) begin
            bcnt  <= bcnt + 2'd1;
            shreg <= {data_i, shreg[23:8]};
            if (bcnt == 2'd3) begin
              we_o    <= 1'b1;
              wdata_o <= word_full;
              waddr_o <= addr;
              addr    <= addr + 32'd4;
              wcnt    <= wcnt_nxt;
              if (wcnt_nxt == n) begin
                state   <= DONE;
                ready_o <= 1'b0;
                busy_o  <= 1'b0;
                done_o  <= 1'b1;
              end
            end
          end
        end
        DONE, ERR: begin
          if (start_i) begin
            state   <= HDR;
            bcnt    <= '0;
            n       <= '0;
            wcnt    <= '0;
            addr    <= BASE_ADDR;
            ready_o <= 1'b1;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
            error_o <= 1'b0;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: table of load cases streamed byte by byte, a write scoreboard,
// plus hand-written reset-mid-word and restart sequences.
module tb_instr_loader;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        ready_o;
  logic        start_i;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] wdata_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  instr_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .start_i(start_i), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
  } exp_t;

  typedef struct {
    logic [31:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    int unsigned gap;
    bit          start_mid;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  exp_t        sb[$];
  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned writes    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk_i) begin
    if (we_o === 1'b1) begin
      exp_t e;
      writes++;
      if (sb.size() == 0) begin
        check("unexpected_write", waddr_o, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        check("waddr", waddr_o, e.addr);
        check("wdata", wdata_o, e.data);
        check("done_with_we", {31'd0, done_o}, {31'd0, e.last});
        check("busy_with_we", {31'd0, busy_o}, {31'd0, !e.last});
      end
    end
  end

  function automatic logic [31:0] word_at(input int unsigned i, input logic [31:0] w0,
                                          input logic [31:0] w1);
    if (i == 0) return w0;
    if (i == 1) return w1;
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int unsigned gap, input bit strobe);
    while ($urandom_range(99) < gap) begin
      valid_i = 1'b0;
      @(negedge clk_i);
    end
    valid_i = 1'b1;
    data_i  = b;
    start_i = strobe;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned gap, input bit strobe);
    for (int unsigned k = 0; k < 4; k++) begin
      logic [31:0] t;
      t = w >> (8 * k);
      send_byte(t[7:0], gap, strobe && (k == 1));
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("restart_ready", {31'd0, ready_o}, 32'd1);
    check("restart_done", {31'd0, done_o}, 32'd0);
    check("restart_err", {31'd0, error_o}, 32'd0);
    check("restart_busy", {31'd0, busy_o}, 32'd1);
  endtask

  task automatic run_load(input vec_t v);
    writes = 0;
    send_word(v.n, v.gap, 1'b0);
    if (v.exp_err) begin
      valid_i = 1'b0;
      check("err_flag", {31'd0, error_o}, 32'd1);
      check("err_ready", {31'd0, ready_o}, 32'd0);
      check("err_busy", {31'd0, busy_o}, 32'd1);
      check("err_done", {31'd0, done_o}, 32'd0);
      valid_i = 1'b1;
      data_i  = 8'h5A;
      repeat (8) @(negedge clk_i);
      valid_i = 1'b0;
      check("err_flag_hold", {31'd0, error_o}, 32'd1);
    end else begin
      for (int unsigned i = 0; i < v.n; i++) begin
        exp_t e;
        e.addr = BASE + 32'(i) * 32'd4;
        e.data = word_at(i, v.w0, v.w1);
        e.last = (i == v.n - 1);
        sb.push_back(e);
        send_word(e.data, v.gap, v.start_mid && (i == 0));
        check("we_latency", {31'd0, we_o}, 32'd1);
      end
      valid_i = 1'b0;
      check("done_flag", {31'd0, done_o}, {31'd0, v.exp_done});
      check("done_busy", {31'd0, busy_o}, 32'd0);
      check("done_ready", {31'd0, ready_o}, 32'd0);
      @(negedge clk_i);
    end
    check("write_count", writes, v.exp_err ? 32'd0 : v.n);
    check("sb_empty", sb.size(), 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_we", {31'd0, we_o}, 32'd0);
    check("rst_waddr", waddr_o, BASE);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd1);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err", {31'd0, error_o}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{32'd2,    32'h0050_0093, 32'h0010_0113, 0,  1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'd2,    32'h0050_0093, 32'h0010_0113, 50, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'd0,    32'h0,         32'h0,         0,  1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'd1025, 32'h0,         32'h0,         0,  1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'd1024, 32'h1111_2222, 32'h3333_4444, 0,  1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'd1,    32'hDEAD_BEEF, 32'h0,         0,  1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'd3,    32'hCAFE_F00D, 32'h1234_5678, 25, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h0,    32'h0,         0,  1'b0, 1'b0, 1'b1};
    vecs[8] = '{32'hFFFF_FFFF, 32'h0,    32'h0,         30, 1'b0, 1'b0, 1'b1};

    rst_i   = 1'b1;
    valid_i = 1'b0;
    start_i = 1'b0;
    data_i  = 8'h00;
    repeat (3) @(negedge clk_i);
    check_reset_vals();
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int unsigned v = 0; v < 9; v++) begin
      if (v != 0) pulse_start();
      run_load(vecs[v]);
    end

    // Reset after header plus two data bytes: the partial word must vanish.
    pulse_start();
    writes = 0;
    send_word(32'd2, 0, 1'b0);
    send_byte(8'h93, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    valid_i = 1'b0;
    rst_i   = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_reset_vals();
    repeat (3) @(negedge clk_i);
    check("post_rst_writes", writes, 32'd0);
    run_load(vecs[0]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
